// File: rtl/es24_pkg.sv
// ============================================================================
// Module      : es24_pkg
// Description : Shared types and constants for the ES24 card-cycle sequencer.
//               Holds the command opcode enum, the sequencer state enum, the
//               brush phase order (phase index -> timing bit) and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package es24_pkg;

    typedef enum logic [1:0] {
        ES24_OP_ADD     = 2'd0,
        ES24_OP_SUB     = 2'd1,
        ES24_OP_CLEAR   = 2'd2,
        ES24_OP_ANALYSE = 2'd3
    } es24_op_e;

    // ST_GAP is only reachable when the inter-phase gap is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } es24_state_e;

    localparam int ES24_NPHASES = 15;
    localparam int ES24_GAP_LEN = 4;

    // Phase index of T11; the counter analysis is sampled at its end.
    localparam logic [3:0] ES24_IDX_T11 = 4'd1;

    // Brush order T12, T11, T9..T0, T13, T14, T15. Element [0] is the first
    // phase of a card cycle; T10 is never sensed.
    localparam logic [ES24_NPHASES-1:0][3:0] ES24_PHASE_ORDER = {
        4'd15, 4'd14, 4'd13, 4'd0, 4'd1, 4'd2, 4'd3,
        4'd4,  4'd5,  4'd6,  4'd7, 4'd8, 4'd9, 4'd11, 4'd12
    };

    function automatic logic [3:0] es24_phase_bit(input logic [3:0] idx);
        logic [3:0] tbit;
        tbit = 4'd0;
        if (int'(idx) < ES24_NPHASES) begin
            tbit = ES24_PHASE_ORDER[idx];
        end
        return tbit;
    endfunction

    // True when any of the twelve BCD nibbles is not a decimal digit.
    function automatic logic es24_has_bad_digit(input logic [47:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (digits[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/es24_phase_timer.sv
// ============================================================================
// Module      : es24_phase_timer
// Description : Sub-counter and phase index for one ES24 card cycle.
//               start      - clear to the first clock of T12 (priority)
//               run        - advance by one clock
//               phase_idx  - current phase index 0..14
//               phase_last - last clock of the current phase (never in gap)
//               cycle_last - last clock of the whole card cycle
//               in_gap     - currently inside an inter-phase gap
//               nxt_*      - values the index/gap flag take after this clock,
//                            so the owner can register decoded outputs
// Config      : ES24_ZYKLUS_GAP_EN adds ES24_GAP_LEN idle clocks after each
//               phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module es24_phase_timer
    import es24_pkg::*;
#(
    parameter int PHASE_LEN = 32
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       run,
    output logic [3:0] phase_idx,
    output logic [3:0] nxt_phase_idx,
    output logic       phase_last,
    output logic       cycle_last,
    output logic       in_gap,
    output logic       nxt_in_gap
);

    localparam int               SUB_W    = $clog2(PHASE_LEN);
    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(PHASE_LEN - 1);
    localparam logic [3:0]       LAST_IDX = 4'(ES24_NPHASES - 1);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       phase_q, phase_d;
    logic             sub_wrap;
    logic             on_last_phase;

    assign sub_wrap      = (sub_q == SUB_MAX);
    assign on_last_phase = (phase_q == LAST_IDX);

`ifdef ES24_ZYKLUS_GAP_EN
    logic       gap_q, gap_d;
    logic [1:0] gap_cnt_q, gap_cnt_d;
    logic       gap_wrap;

    assign gap_wrap = (gap_cnt_q == 2'(ES24_GAP_LEN - 1));

    always_comb begin
        sub_d     = sub_q;
        phase_d   = phase_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        if (start) begin
            sub_d     = '0;
            phase_d   = '0;
            gap_d     = 1'b0;
            gap_cnt_d = '0;
        end else if (run) begin
            if (gap_q) begin
                if (gap_wrap) begin
                    gap_d     = 1'b0;
                    gap_cnt_d = '0;
                    if (!on_last_phase) begin
                        phase_d = phase_q + 4'd1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 2'd1;
                end
            end else if (sub_wrap) begin
                sub_d     = '0;
                gap_d     = 1'b1;
                gap_cnt_d = '0;
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_q     <= '0;
            phase_q   <= '0;
            gap_q     <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            sub_q     <= sub_d;
            phase_q   <= phase_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign phase_last = !gap_q && sub_wrap;
    assign cycle_last = gap_q && gap_wrap && on_last_phase;
    assign in_gap     = gap_q;
    assign nxt_in_gap = gap_d;
`else
    always_comb begin
        sub_d   = sub_q;
        phase_d = phase_q;
        if (start) begin
            sub_d   = '0;
            phase_d = '0;
        end else if (run) begin
            if (sub_wrap) begin
                sub_d = '0;
                if (!on_last_phase) begin
                    phase_d = phase_q + 4'd1;
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_q   <= '0;
            phase_q <= '0;
        end else begin
            sub_q   <= sub_d;
            phase_q <= phase_d;
        end
    end

    assign phase_last = sub_wrap;
    assign cycle_last = sub_wrap && on_last_phase;
    assign in_gap     = 1'b0;
    assign nxt_in_gap = 1'b0;
`endif

    assign phase_idx     = phase_q;
    assign nxt_phase_idx = phase_d;

endmodule

`default_nettype wire

// File: rtl/es24_kartenzyklus.sv
// ============================================================================
// Module      : es24_kartenzyklus
// Description : ES24 card-cycle sequencer. Accepts one punched-card command
//               over valid/ready and plays the brush timing, digit punches
//               and counter controls for one full card cycle.
// Ports       : clk, reset (async, active-low)
//               cmd_valid/cmd_ready, cmd_op, cmd_neg, cmd_digits[47:0]
//               timing[15:0], data[12:1]
//               aufnahme_out, umkehr_out, minus_out, loeschen_out, za_req_out
//               zaehleranalyse (in)
//               done_valid, done_za, done_err
// Config      : ES24_ZYKLUS_GAP_EN inserts an all-zero gap after each phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module es24_kartenzyklus
    import es24_pkg::*;
#(
    parameter int PHASE_LEN = 32
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_neg,
    input  logic [47:0] cmd_digits,
    output logic [15:0] timing,
    output logic [12:1] data,
    output logic        aufnahme_out,
    output logic        umkehr_out,
    output logic        minus_out,
    output logic        loeschen_out,
    output logic        za_req_out,
    input  logic        zaehleranalyse,
    output logic        done_valid,
    output logic        done_za,
    output logic        done_err
);

    es24_state_e state_q, state_d;
    es24_op_e    op_q, op_d;
    logic        neg_q, neg_d;
    logic [47:0] digits_q, digits_d;
    logic        err_q, err_d;
    logic        za_q, za_d;

    logic [15:0] timing_q, timing_d;
    logic [12:1] data_q, data_d;
    logic        aufnahme_q, aufnahme_d;
    logic        umkehr_q, umkehr_d;
    logic        minus_q, minus_d;
    logic        loeschen_q, loeschen_d;
    logic        za_req_q, za_req_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        done_valid_q, done_valid_d;
    logic        done_za_q, done_za_d;
    logic        done_err_q, done_err_d;

    logic        accept;
    logic        timer_run;
    logic [3:0]  phase_idx;
    logic [3:0]  nxt_phase_idx;
    logic        phase_last;
    logic        cycle_last;
    logic        timer_in_gap;
    logic        nxt_in_gap;
    logic        za_sample;
    logic [3:0]  tbit;
    logic        addsub_d;

    assign accept    = cmd_valid && cmd_ready_q;
    assign timer_run = (state_q == ST_RUN) || (state_q == ST_GAP);

    es24_phase_timer #(
        .PHASE_LEN (PHASE_LEN)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .start         (accept),
        .run           (timer_run),
        .phase_idx     (phase_idx),
        .nxt_phase_idx (nxt_phase_idx),
        .phase_last    (phase_last),
        .cycle_last    (cycle_last),
        .in_gap        (timer_in_gap),
        .nxt_in_gap    (nxt_in_gap)
    );

    // Counter analysis is taken on the final clock of T11, never in a gap.
    assign za_sample = (state_q == ST_RUN) && !timer_in_gap && phase_last &&
                       (phase_idx == ES24_IDX_T11) && (op_q == ES24_OP_ANALYSE);

    // Next state and command latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        digits_d = digits_q;
        err_d    = err_q;
        za_d     = za_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_GAP: begin
                if (cycle_last) begin
                    state_d = ST_DONE;
                end else if (nxt_in_gap) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            op_d     = es24_op_e'(cmd_op);
            neg_d    = cmd_neg;
            digits_d = cmd_digits;
            err_d    = ((cmd_op == 2'(ES24_OP_ADD)) || (cmd_op == 2'(ES24_OP_SUB))) &&
                       es24_has_bad_digit(cmd_digits);
            za_d     = 1'b0;
        end else if (za_sample) begin
            za_d = zaehleranalyse;
        end
    end

    // Output decode from the next-cycle state, so every output is a flop and
    // T12 appears on the clock right after the accept edge.
    always_comb begin
        tbit         = es24_phase_bit(nxt_phase_idx);
        addsub_d     = (op_d == ES24_OP_ADD) || (op_d == ES24_OP_SUB);
        timing_d     = '0;
        data_d       = '0;
        aufnahme_d   = 1'b0;
        umkehr_d     = 1'b0;
        minus_d      = 1'b0;
        loeschen_d   = 1'b0;
        za_req_d     = 1'b0;

        if (state_d == ST_RUN) begin
            timing_d[tbit] = 1'b1;
            // A nibble matches only a decimal phase, so >9 never punches.
            for (int n = 1; n <= 12; n++) begin
                if (addsub_d && (tbit <= 4'd9) && (digits_d[4*n-1 -: 4] == tbit)) begin
                    data_d[n] = 1'b1;
                end
            end
            aufnahme_d = addsub_d && ((tbit == 4'd12) || (tbit == 4'd11));
            umkehr_d   = (op_d == ES24_OP_SUB) && ((tbit == 4'd12) || (tbit == 4'd11));
            minus_d    = addsub_d && neg_d && (tbit == 4'd11);
            loeschen_d = (op_d == ES24_OP_CLEAR) && (tbit == 4'd12);
            za_req_d   = (op_d == ES24_OP_ANALYSE) && (tbit == 4'd12);
        end

        cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
        done_valid_d = (state_d == ST_DONE);
        done_za_d    = done_valid_d && za_q;
        done_err_d   = done_valid_d && err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= ES24_OP_ADD;
            neg_q        <= 1'b0;
            digits_q     <= '0;
            err_q        <= 1'b0;
            za_q         <= 1'b0;
            timing_q     <= '0;
            data_q       <= '0;
            aufnahme_q   <= 1'b0;
            umkehr_q     <= 1'b0;
            minus_q      <= 1'b0;
            loeschen_q   <= 1'b0;
            za_req_q     <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_valid_q <= 1'b0;
            done_za_q    <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            digits_q     <= digits_d;
            err_q        <= err_d;
            za_q         <= za_d;
            timing_q     <= timing_d;
            data_q       <= data_d;
            aufnahme_q   <= aufnahme_d;
            umkehr_q     <= umkehr_d;
            minus_q      <= minus_d;
            loeschen_q   <= loeschen_d;
            za_req_q     <= za_req_d;
            cmd_ready_q  <= cmd_ready_d;
            done_valid_q <= done_valid_d;
            done_za_q    <= done_za_d;
            done_err_q   <= done_err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign timing       = timing_q;
    assign data         = data_q;
    assign aufnahme_out = aufnahme_q;
    assign umkehr_out   = umkehr_q;
    assign minus_out    = minus_q;
    assign loeschen_out = loeschen_q;
    assign za_req_out   = za_req_q;
    assign done_valid   = done_valid_q;
    assign done_za      = done_za_q;
    assign done_err     = done_err_q;

endmodule

`default_nettype wire

// File: doc/es24_kartenzyklus.md
# es24_kartenzyklus

Card-cycle sequencer for the ES24 counter bank. It accepts one punched-card command per cycle over a valid/ready handshake. It then generates the complete brush timing sequence (`timing[15:0]`) and the per-column digit-punch signals (`data[12:1]`), and drives the counter control inputs: Aufnahme, Umkehr, Minus, Löschen and Zählerabfrage. It replaces hand-written bench stimulus with the machine's real cycle schedule and sits directly in front of `es24`.

## Interface
Parameters:
- `PHASE_LEN`, default 32: clocks per timing phase; legal range 4..255.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block idle; the command is accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  operation: 0 ADD, 1 SUB, 2 CLEAR, 3 ANALYSE.
- `cmd_neg`  in  1  card sign (row-11 punch).
- `cmd_digits`  in  48  twelve BCD nibbles; `[3:0]` is column 1 (least significant).
- `timing`  out  16  one-hot brush phase.
- `data`  out  12  `[12:1]`, punch sensed in the current phase.
- `aufnahme_out`, `umkehr_out`, `minus_out`, `loeschen_out`, `za_req_out`  out  1 each  counter controls; each `_out` drives both `_in1`/`_in2` where the counter has a pair.
- `zaehleranalyse`  in  1  counter analysis result.
- `done_valid`  out  1  one-clock completion pulse.
- `done_za`  out  1  sampled analysis result; valid with `done_valid`.
- `done_err`  out  1  a nibble was >9; valid with `done_valid`.

## Operation
- States: IDLE, RUN, DONE (plus GAP when configured).
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch op, sign and digits, clear the phase index and sub-counter, and go to RUN.
- RUN steps the fixed phase order T12, T11, T9, T8, T7, T6, T5, T4, T3, T2, T1, T0, T13, T14, T15. That is 15 phases, index 0..14.
  - `timing[k]`=1 for all `PHASE_LEN` clocks of phase Tk.
  - After the last clock of T15, go to DONE.
- `data[n]`=1 throughout phase Tv, where v = nibble n.
  - This applies to ADD/SUB only, and only when v≤9.
  - A nibble >9 asserts nothing and sets the `done_err` latch.
- ADD/SUB control outputs:
  - `aufnahme_out`=1 during T12 and T11.
  - `umkehr_out`=1 during T12 and T11 when op=SUB.
  - `minus_out`=1 during T11 when `cmd_neg`=1.
- CLEAR:
  - `loeschen_out`=1 during T12 only.
  - `data` and the other controls stay 0.
- ANALYSE:
  - `za_req_out`=1 during T12.
  - `zaehleranalyse` is sampled on the last clock of T11 into `done_za`.
- DONE lasts one clock:
  - `done_valid`=1; `done_za` and `done_err` are valid.
  - `cmd_ready`=1 in the same clock, which permits back-to-back commands.
  - If a command is accepted in DONE, T12 starts on the next clock; otherwise the block returns to IDLE.
- Commands offered while busy are held off (`cmd_ready`=0). The latched command is immune to input changes.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - All other outputs 0, including `done_za` and `done_err`.
  - State IDLE.
- Reset mid-cycle: all outputs drop to their reset values asynchronously. No `done_valid` is issued, and the aborted command is lost.
- Accept-to-T12 latency: 1 clock. T12 starts on the clock after the accept edge.
- Cycle length: 15·`PHASE_LEN` clocks of timing, then 1 DONE clock.
- All outputs are registered. `timing`, `data` and the controls change only on phase boundaries.
- Phase sub-counter: width `$clog2(PHASE_LEN)`, wraps at `PHASE_LEN`-1.

## Configuration
- `ES24_ZYKLUS_GAP_EN`:
  - **Defined:** each phase is followed by 4 GAP clocks in which `timing`, `data` and all controls are 0. This guarantees falling edges for the counter's edge detectors. Cycle length becomes 15·(`PHASE_LEN`+4). `zaehleranalyse` is still sampled on the last T11 clock, not in the gap.
  - **Undefined:** no GAP state; phases are contiguous.

## Structure
- `es24_pkg` contains:
  - The op enum (`ES24_OP_ADD/SUB/CLEAR/ANALYSE`).
  - `ES24_NPHASES`=15.
  - The phase-order constant array (index → timing bit).
  - `ES24_GAP_LEN`=4.
- Sub-module `es24_phase_timer` contains the sub-counter and phase index, with outputs `phase_idx`, `phase_last`, `cycle_last` and `in_gap`.
- The top level holds the FSM, the command latch and output decode.

## Test plan
All scenarios use `PHASE_LEN`=4, no gap, with cycle 0 = first T12 clock.
- **ADD:** nibble1=3, others 0, `cmd_neg`=0.
  - `aufnahme_out`=1 at cycles 0–7.
  - `data[1]`=1 at cycles 32–35 (T3); `data[2..12]`=1 at cycles 44–47 (T0).
  - `done_valid` at cycle 60.
- **SUB:** `cmd_neg`=1, nibble12=9.
  - `umkehr_out`=1 at cycles 0–7.
  - `minus_out`=1 at cycles 4–7.
  - `data[12]`=1 at cycles 8–11.
- **CLEAR:**
  - `loeschen_out`=1 at cycles 0–3.
  - `data`=0 and `aufnahme_out`=0 throughout.
  - `done_err`=0.
- **ANALYSE:**
  - `zaehleranalyse`=1 at cycle 7 gives `done_za`=1.
  - A rerun with `zaehleranalyse`=0 at cycle 7 gives `done_za`=0.
- **Invalid digit:** nibble5=0xA.
  - `data[5]` never asserts.
  - `done_err`=1 at cycle 60.
- **Back-to-back and reset:**
  - A second command offered at cycle 60 is accepted, and its T12 starts at cycle 61.
  - Asserting `reset` at cycle 20 zeroes `timing` immediately, gives `cmd_ready`=1, and no `done_valid` follows.
